// File: rtl/key_highlight_sched.sv
// ============================================================================
// key_highlight_sched -- frame-synchronous scheduler of up to MAX_ACT key highlights.  Rev 1.0
// ============================================================================
`default_nettype none

module key_highlight_sched #(
    parameter int N_KEYS      = 8,
    parameter int HOLD_FRAMES = 6,
    parameter int MAX_ACT     = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              vsync_i,
    input  logic [N_KEYS-1:0] key_req_i,
    output logic [N_KEYS-1:0] key_active_o,
    output logic [3:0]        active_cnt_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int            HW     = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] C_HOLD = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] C_ONE  = HW'(1);
    localparam logic [3:0]    C_MAX  = 4'(MAX_ACT);

    logic [N_KEYS-1:0]         ks1_q, ks2_q, ks3_q;
    logic                      vsync_q;
    logic [N_KEYS-1:0]         pending_q, pending_d;
    logic [N_KEYS-1:0]         active_q, active_d;
    logic [N_KEYS-1:0][HW-1:0] hold_q, hold_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic [15:0]               frame_q, frame_d;
    logic [N_KEYS-1:0]         press;
    logic                      tick;
    logic [3:0]                used;

    always_comb begin
        press     = ks2_q & ~ks3_q;
        tick      = vsync_i & ~vsync_q;
        active_d  = active_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        frame_d   = frame_q;
        used      = '0;
        if (tick) begin
            // Refresh/expire active keys first so freed slots are grantable this tick.
            for (int i = 0; i < N_KEYS; i++) begin
                if (active_q[i]) begin
                    if (ks2_q[i]) begin
                        hold_d[i] = C_HOLD;
                    end else begin
                        if (hold_q[i] != '0) hold_d[i] = hold_q[i] - C_ONE;
                        if (hold_q[i] <= C_ONE) active_d[i] = 1'b0;
                    end
                    if (active_d[i] && pending_q[i]) begin
                        pending_d[i] = 1'b0;
                        hold_d[i]    = C_HOLD;
                    end
                end
            end
            used = 4'($countones(active_d));
            for (int i = 0; i < N_KEYS; i++) begin
                if (pending_q[i] && !active_d[i] && (used < C_MAX)) begin
                    active_d[i]  = 1'b1;
                    hold_d[i]    = C_HOLD;
                    pending_d[i] = 1'b0;
                    used         = used + 4'd1;
                end
            end
            frame_d = frame_q + 16'd1;
        end
        // A press landing on the tick edge waits for the following tick.
        pending_d = pending_d | press;
        cnt_d     = 4'($countones(active_d));
        busy_d    = (|pending_d) && (cnt_d == C_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ks1_q     <= '0;
            ks2_q     <= '0;
            ks3_q     <= '0;
            vsync_q   <= 1'b0;
            pending_q <= '0;
            active_q  <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            frame_q   <= '0;
        end else if (!en_i) begin
            ks1_q     <= '0;
            ks2_q     <= '0;
            ks3_q     <= '0;
            vsync_q   <= 1'b0;
            pending_q <= '0;
            active_q  <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            frame_q   <= '0;
        end else begin
            ks1_q     <= key_req_i;
            ks2_q     <= ks1_q;
            ks3_q     <= ks2_q;
            vsync_q   <= vsync_i;
            pending_q <= pending_d;
            active_q  <= active_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            frame_q   <= frame_d;
        end
    end

    assign key_active_o = active_q;
    assign active_cnt_o = cnt_q;
    assign busy_o       = busy_q;
    assign frame_cnt_o  = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_key_highlight_sched.sv
// ============================================================================
// tb_key_highlight_sched -- directed self-checking bench for key_highlight_sched.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_highlight_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        vsync_i;
    logic [7:0]  key_req_i;
    logic [7:0]  key_active_o;
    logic [3:0]  active_cnt_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    key_highlight_sched #(
        .N_KEYS      (8),
        .HOLD_FRAMES (6),
        .MAX_ACT     (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .vsync_i      (vsync_i),
        .key_req_i    (key_req_i),
        .key_active_o (key_active_o),
        .active_cnt_o (active_cnt_o),
        .busy_o       (busy_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One low cycle then one rising vsync; returns just after the tick edge.
    task automatic tick();
        vsync_i = 1'b0;
        step(1);
        vsync_i = 1'b1;
        step(1);
        vsync_i = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni    = 1'b1;
        en_i      = 1'b1;
        vsync_i   = 1'b0;
        key_req_i = 8'hFF;
        #3 rst_ni = 1'b0;
        vsync_i   = 1'b1;
        step(3);
        chk("rst_active", 32'(key_active_o), 32'h00);
        chk("rst_cnt",    32'(active_cnt_o), 32'h0);
        chk("rst_busy",   32'(busy_o),       32'h0);
        chk("rst_frame",  32'(frame_cnt_o),  32'h0);
        vsync_i = 1'b0;
        step(1);

        // Released with all keys requested but no frame edge.
        rst_ni = 1'b1;
        step(6);
        chk("no_tick_active", 32'(key_active_o), 32'h00);
        chk("no_tick_frame",  32'(frame_cnt_o),  32'h0);

        // Reset mid-operation must discard the pending requests.
        rst_ni    = 1'b0;
        key_req_i = 8'h00;
        step(1);
        rst_ni = 1'b1;
        step(3);
        tick();
        chk("rst_discard_active", 32'(key_active_o), 32'h00);
        chk("rst_discard_frame",  32'(frame_cnt_o),  32'h1);

        // Single press of key 2.
        key_req_i = 8'h04;
        step(2);
        tick();
        chk("k2_active", 32'(key_active_o), 32'h04);
        chk("k2_cnt",    32'(active_cnt_o), 32'h1);
        chk("k2_frame",  32'(frame_cnt_o),  32'h2);
        step(3);
        chk("k2_between", 32'(key_active_o), 32'h04);

        key_req_i = 8'h00;
        step(3);
        for (int k = 0; k < 5; k++) tick();
        chk("k2_hold5", 32'(key_active_o), 32'h04);
        tick();
        chk("k2_expire", 32'(key_active_o), 32'h00);
        chk("k2_expire_frame", 32'(frame_cnt_o), 32'h8);

        // Short tap of key 5 between ticks.
        key_req_i = 8'h20;
        step(4);
        key_req_i = 8'h00;
        step(3);
        chk("tap_not_yet", 32'(key_active_o), 32'h00);
        tick();
        chk("tap_grant", 32'(key_active_o), 32'h20);
        for (int k = 0; k < 5; k++) tick();
        chk("tap_hold5", 32'(key_active_o), 32'h20);
        tick();
        chk("tap_expire", 32'(key_active_o), 32'h00);
        chk("tap_frame",  32'(frame_cnt_o),  32'hF);

        // Oversubscription: keys 0,1,4,6 compete for three slots.
        key_req_i = 8'h53;
        step(2);
        tick();
        chk("full_active", 32'(key_active_o), 32'h13);
        chk("full_cnt",    32'(active_cnt_o), 32'h3);
        chk("full_busy",   32'(busy_o),       32'h1);
        key_req_i = 8'h52;
        step(3);
        for (int k = 0; k < 5; k++) tick();
        chk("full_hold5_active", 32'(key_active_o), 32'h13);
        chk("full_hold5_busy",   32'(busy_o),       32'h1);
        tick();
        chk("swap_active", 32'(key_active_o), 32'h52);
        chk("swap_cnt",    32'(active_cnt_o), 32'h3);
        chk("swap_busy",   32'(busy_o),       32'h0);
        chk("swap_frame",  32'(frame_cnt_o),  32'h16);

        key_req_i = 8'h00;
        step(3);
        for (int k = 0; k < 6; k++) tick();
        chk("all_expire", 32'(key_active_o), 32'h00);

        // Key 3 re-pressed while still lit reloads its hold count.
        key_req_i = 8'h08;
        step(2);
        tick();
        chk("k3_grant", 32'(key_active_o), 32'h08);
        key_req_i = 8'h00;
        step(3);
        for (int k = 0; k < 3; k++) tick();
        key_req_i = 8'h08;
        step(2);
        tick();
        key_req_i = 8'h00;
        step(3);
        for (int k = 0; k < 5; k++) tick();
        chk("k3_reload_hold5", 32'(key_active_o), 32'h08);
        tick();
        chk("k3_reload_expire", 32'(key_active_o), 32'h00);
        chk("k3_frame",         32'(frame_cnt_o),  32'h27);

        // Enable drop mid-highlight clears everything on the next edge.
        key_req_i = 8'h08;
        step(2);
        tick();
        chk("en_pre_active", 32'(key_active_o), 32'h08);
        en_i = 1'b0;
        step(1);
        en_i = 1'b1;
        chk("en_active", 32'(key_active_o), 32'h00);
        chk("en_cnt",    32'(active_cnt_o), 32'h0);
        chk("en_busy",   32'(busy_o),       32'h0);
        chk("en_frame",  32'(frame_cnt_o),  32'h0);
        step(3);
        tick();
        chk("en_regrant", 32'(key_active_o), 32'h08);
        chk("en_frame1",  32'(frame_cnt_o),  32'h1);

        // Frame counter wrap.
        force dut.frame_q = 16'hFFFF;
        #1 release dut.frame_q;
        #1;
        chk("wrap_preset", 32'(frame_cnt_o), 32'hFFFF);
        tick();
        chk("wrap_frame",  32'(frame_cnt_o), 32'h0);
        chk("wrap_active", 32'(key_active_o), 32'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
